// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-lite main controller sequencing IF/ID/EXE/MEM/WB
// with req/ack memory handshakes and a retired-instruction counter.
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             alu_zero,
   input  logic             im_ack,
   input  logic             dm_ack,
   output logic             im_req,
   output logic             ir_wr,
   output logic             pc_wr,
   output logic [1:0]       npc_op,
   output logic             ext_op,
   output logic [1:0]       alu_op,
   output logic             alu_src_b,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_wr,
   output logic             dm_req,
   output logic             dm_we,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);
   typedef enum logic [2:0] {S_IF, S_ID, S_EXE, S_MEM, S_WB} state_t;
   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_retired;
   logic w_rtype, w_addu, w_subu, w_addiu, w_ori, w_lui, w_lw, w_sw, w_beq, w_j;
   logic w_legal, w_inc, w_alu_phase;
   logic [1:0] w_alu_op;
   assign w_rtype  = opcode == 6'b000000;
   assign w_addu   = w_rtype && funct == 6'b100001;
   assign w_subu   = w_rtype && funct == 6'b100011;
   assign w_addiu  = opcode == 6'b001001;
   assign w_ori    = opcode == 6'b001101;
   assign w_lui    = opcode == 6'b001111;
   assign w_lw     = opcode == 6'b100011;
   assign w_sw     = opcode == 6'b101011;
   assign w_beq    = opcode == 6'b000100;
   assign w_j      = opcode == 6'b000010;
   assign w_legal  = w_addu | w_subu | w_addiu | w_ori | w_lui | w_lw | w_sw | w_beq | w_j;
   assign w_alu_op = (w_subu | w_beq) ? 2'd1 : w_ori ? 2'd2 : w_lui ? 2'd3 : 2'd0;
   // ALU configuration stays driven through MEM/WB so address and result remain stable
   assign w_alu_phase = r_state == S_EXE || r_state == S_MEM || r_state == S_WB;
   assign retired = r_retired;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IF;
         r_retired <= '0;
      end else begin
         r_state   <= w_next;
         r_retired <= r_retired + CNT_W'(w_inc);
      end
   end
   always_comb begin
      w_next     = r_state;
      w_inc      = 1'b0;
      im_req     = 1'b0;
      ir_wr      = 1'b0;
      pc_wr      = 1'b0;
      npc_op     = 2'd0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_wr     = 1'b0;
      dm_req     = 1'b0;
      dm_we      = 1'b0;
      illegal    = 1'b0;
      ext_op     = w_addiu | w_lw | w_sw | w_beq;
      alu_op     = w_alu_phase ? w_alu_op : 2'd0;
      alu_src_b  = w_alu_phase & (w_addiu | w_ori | w_lui | w_lw | w_sw);
      case (r_state)
         S_IF: begin
            im_req = 1'b1;
            ir_wr  = im_ack;
            pc_wr  = im_ack;
            w_next = im_ack ? S_ID : S_IF;
         end
         S_ID: begin
            pc_wr   = w_j;
            npc_op  = w_j ? 2'd2 : 2'd0;
            w_inc   = w_j;
            illegal = ~w_legal;
            w_next  = (w_j || !w_legal) ? S_IF : S_EXE;
         end
         S_EXE: begin
            pc_wr  = w_beq & alu_zero;
            npc_op = w_beq ? 2'd1 : 2'd0;
            w_inc  = w_beq;
            w_next = w_beq ? S_IF : (w_lw | w_sw) ? S_MEM : S_WB;
         end
         S_MEM: begin
            dm_req = 1'b1;
            dm_we  = w_sw;
            w_inc  = dm_ack & w_sw;
            w_next = !dm_ack ? S_MEM : w_sw ? S_IF : S_WB;
         end
         S_WB: begin
            reg_wr     = 1'b1;
            reg_dst    = w_rtype;
            mem_to_reg = w_lw;
            w_inc      = 1'b1;
            w_next     = S_IF;
         end
         default: w_next = S_IF;
      endcase
      if (!rst_n)
         {im_req, ir_wr, pc_wr, npc_op, ext_op, alu_op, alu_src_b, reg_dst, mem_to_reg, reg_wr, dm_req, dm_we, illegal} = 15'd0;
   end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle main controller for the MIPS-lite datapath. Sequences fetch, decode, execute, memory and writeback over several cycles. Drives all datapath configuration: the immediate extender mode, ALU op, mux selects, next-PC select and register/memory write strobes. Handshakes with instruction and data memories via req/ack and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from IR
funct  in  6  instr[5:0] from IR
alu_zero  in  1  ALU result==0 flag, valid in S_EXE
im_ack  in  1  instruction memory data valid
dm_ack  in  1  data memory access complete
im_req  out  1  instruction fetch request
ir_wr  out  1  load IR
pc_wr  out  1  load PC
npc_op  out  2  0=PC+4, 1=branch (PC+4+ext<<2), 2=jump
ext_op  out  1  0=zero-extend imm16, 1=sign-extend
alu_op  out  2  0=add, 1=sub, 2=or, 3=lui (imm<<16)
alu_src_b  out  1  0=rt, 1=extended imm
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALU result, 1=DM data
reg_wr  out  1  register file write strobe
dm_req  out  1  data memory request
dm_we  out  1  data memory write (valid with dm_req)
illegal  out  1  one-cycle pulse on undecodable instruction
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: async on rst_n low; state=S_IF, retired=0. While rst_n low all strobes (im_req, ir_wr, pc_wr, reg_wr, dm_req, dm_we, illegal) forced 0; selects 0.
- State register and retired are the only flops; outputs decoded combinationally from state, opcode, funct, alu_zero, acks.
- Decode: R-type opcode 000000 with funct 100001 ADDU / 100011 SUBU; ADDIU 001001; ORI 001101; LUI 001111; LW 100011; SW 101011; BEQ 000100; J 000010. Anything else illegal, incl. R-type with other funct.
- ext_op=1 for ADDIU, LW, SW, BEQ; 0 otherwise. Held stable in all states for current IR.
- S_IF: im_req=1. Wait while im_ack=0. On im_ack: ir_wr=1, pc_wr=1, npc_op=0; next S_ID.
- S_ID (1 cycle): J: pc_wr=1, npc_op=2, retired++, next S_IF. Illegal: illegal=1, retired unchanged, next S_IF (PC already advanced). Else next S_EXE.
- S_EXE (1 cycle): alu_op/alu_src_b per instr (ADDU add/rt, SUBU sub/rt, ADDIU add/imm, ORI or/imm, LUI lui/imm, LW/SW add/imm, BEQ sub/rt). BEQ: pc_wr=alu_zero, npc_op=1, retired++, next S_IF. LW/SW next S_MEM. ALU instrs next S_WB.
- S_MEM: dm_req=1, dm_we=1 for SW. Wait while dm_ack=0. On dm_ack: SW retired++, next S_IF; LW next S_WB.
- S_WB (1 cycle): reg_wr=1; reg_dst=1 for R-type else 0; mem_to_reg=1 for LW; retired++; next S_IF.
- Latencies with zero-wait memory (ack in first req cycle): J 2 cycles, BEQ 3, ALU ops 4, SW 4, LW 5. Each ack-wait cycle adds 1.
- Ack outside matching request state ignored. Req held high until ack; no abort.
- retired wraps to 0 past 2^CNT_W-1.
- Reset mid-instruction: immediate return to S_IF; partial instruction discarded, no strobe emitted.

Test Plan:
- Reset then im_ack=1 constantly with ORI (opcode 001101): cycle sequence IF,ID,EXE,WB; ext_op=0, alu_op=2, alu_src_b=1, reg_wr=1 in WB, reg_dst=0; retired 0->1.
- LW with dm_ack delayed 3 cycles: dm_req high 4 cycles, dm_we=0, ext_op=1; then WB with mem_to_reg=1, reg_wr=1; total 8 cycles.
- BEQ twice, alu_zero=1 then 0: pc_wr=1/npc_op=1 in EXE first time, pc_wr=0 second; retired +2, reg_wr never asserted.
- J: pc_wr in ID with npc_op=2, back in IF next cycle; opcode 111111 -> illegal pulse 1 cycle, retired unchanged.
- SW with im_ack delayed 2 cycles: im_req held 3 cycles, ir_wr only on ack cycle; dm_we=1 with dm_req; no reg_wr.
- Assert rst_n low during S_MEM of LW: dm_req drops same cycle (async), state S_IF after release, retired=0; spurious dm_ack during S_IF ignored.
